// File: rtl/fib_sequencer.sv
// ---------------------------------------------------------------------------
// fib_sequencer
//   Sequencer for the Fibonacci term datapath. It owns the two term registers
//   (a_q = current term, b_q = next term) and the adder between them. On an
//   accepted start it streams up to n_terms_i terms (0,1,1,2,3,...) over a
//   valid/ready handshake and then pulses done_o. If the next term to be
//   emitted does not fit in WIDTH bits, the sequence ends early and the
//   sticky overflow_o flag is set.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   start_i        request a new sequence (only looked at in IDLE)
//   n_terms_i      number of terms requested, latched on an accepted start
//   term_out_o     current term, forced to 0 whenever term_valid_o is low
//   term_valid_o   term_out_o holds a term for the consumer
//   term_ready_i   consumer takes term_out_o when valid and ready are both high
//   busy_o         high while a sequence is in progress (LOAD, EMIT, STEP)
//   done_o         single-cycle pulse when a sequence ends
//   overflow_o     sticky; the last sequence stopped early on overflow
// ---------------------------------------------------------------------------
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for start_i; latches n_terms_i and clears overflow
// LOAD   | seeds A=0, B=1 and clears the emitted-term counter
// EMIT   | presents A until handshake, or ends on a pending overflow
// STEP   | advances the pair: A<=B, B<=A+B, carry tracked in b_ovf
// DONE   | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module fib_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] n_terms_i,
   output logic [WIDTH-1:0] term_out_o,
   output logic             term_valid_o,
   input  logic             term_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             overflow_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_EMIT = 3'd2,
      S_STEP = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             a_ovf_q;
   logic             b_ovf_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] n_lat_q;
   logic             overflow_q;

   logic [WIDTH:0]   sum_d;
   logic [CNT_W-1:0] count_d;
   logic             last_term_d;

   // Extra bit on the adder captures the carry out of the term width.
   assign sum_d       = {1'b0, a_q} + {1'b0, b_q};
   assign count_d     = count_q + CNT_W'(1);
   // n_lat_q never exceeds the counter range, so the count ends on equality
   // and cannot wrap.
   assign last_term_d = (count_d == n_lat_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         a_ovf_q    <= 1'b0;
         b_ovf_q    <= 1'b0;
         count_q    <= '0;
         n_lat_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  n_lat_q    <= n_terms_i;
                  overflow_q <= 1'b0;
                  if (n_terms_i == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end
            end

            S_LOAD: begin
               a_q     <= '0;
               b_q     <= WIDTH'(1);
               a_ovf_q <= 1'b0;
               b_ovf_q <= 1'b0;
               count_q <= '0;
               state_q <= S_EMIT;
            end

            S_EMIT: begin
               // A term whose overflow flag is set never reaches the stream.
               if (a_ovf_q) begin
                  overflow_q <= 1'b1;
                  state_q    <= S_DONE;
               end else if (term_ready_i) begin
                  count_q <= count_d;
                  if (last_term_d) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_STEP;
                  end
               end
            end

            S_STEP: begin
               a_q     <= b_q;
               a_ovf_q <= b_ovf_q;
               b_q     <= sum_d[WIDTH-1:0];
               // Once B has overflowed it stays marked even though the
               // truncated value keeps feeding the adder.
               b_ovf_q <= b_ovf_q | sum_d[WIDTH];
               state_q <= S_EMIT;
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign term_valid_o = (state_q == S_EMIT) && !a_ovf_q;
   assign term_out_o   = term_valid_o ? a_q : '0;
   assign busy_o       = (state_q == S_LOAD) || (state_q == S_EMIT) || (state_q == S_STEP);
   assign done_o       = (state_q == S_DONE);
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fib_sequencer.sv
module tb_fib_sequencer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] n_terms = '0;
   logic             term_ready = 1'b0;
   logic [WIDTH-1:0] term_out;
   logic             term_valid;
   logic             busy;
   logic             done;
   logic             overflow;

   fib_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .n_terms_i    (n_terms),
      .term_out_o   (term_out),
      .term_valid_o (term_valid),
      .term_ready_i (term_ready),
      .busy_o       (busy),
      .done_o       (done),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Reference: the list of terms a sequence of length n must produce, and
   // whether it must stop on overflow.
   int exp_q[$];
   bit exp_ovf = 1'b0;
   bit exp_active = 1'b0;
   int hs_cnt = 0;
   int hs_cyc[$];
   int last_term = -1;
   int done_cyc = -1;

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic model_start(input int n);
      int f0;
      int f1;
      int t;
      f0 = 0;
      f1 = 1;
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (f0 > (1 << WIDTH) - 1) begin
            exp_ovf = 1'b1;
            break;
         end
         exp_q.push_back(f0);
         t  = f0 + f1;
         f0 = f1;
         f1 = t;
      end
      exp_active = 1'b1;
      hs_cnt = 0;
      hs_cyc.delete();
      last_term = -1;
      done_cyc = -1;
   endtask

   // Stream checker: every term, stall stability, zero when idle, done.
   logic [WIDTH-1:0] prev_out = '0;
   bit prev_stall = 1'b0;
   always @(negedge clk) begin
      if (!term_valid) begin
         check("idle_zero", int'(term_out), 0);
      end else begin
         if (prev_stall) check("stall_stable", int'(term_out), int'(prev_out));
         if (term_ready && !reset) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_term actual=%0d required=none", term_out);
            end else begin
               check("term", int'(term_out), exp_q.pop_front());
            end
            hs_cnt++;
            hs_cyc.push_back(cyc);
            last_term = int'(term_out);
         end
      end
      prev_stall = term_valid && !term_ready;
      prev_out   = term_out;
      if (done) begin
         check("done_expected", int'(exp_active), 1);
         check("done_terms_left", exp_q.size(), 0);
         check("done_overflow", int'(overflow), int'(exp_ovf));
         exp_active = 1'b0;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seq(input int n, output int s);
      n_terms = CNT_W'(n);
      start = 1'b1;
      model_start(n);
      tick();
      s = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
   endtask

   task automatic wait_valid(input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         if (term_valid) return;
         tick();
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_valid required=valid", nm);
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_valid"}, int'(term_valid), 0);
      check({nm, "_out"}, int'(term_out), 0);
      check({nm, "_busy"}, int'(busy), 0);
      check({nm, "_done"}, int'(done), 0);
      check({nm, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      bit found;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // 1: five terms at full rate
      term_ready = 1'b1;
      start_seq(5, s);
      check("t1_load_busy", int'(busy), 1);
      check("t1_load_valid", int'(term_valid), 0);
      wait_done(40, "t1");
      // start during DONE must be ignored
      start = 1'b1;
      n_terms = CNT_W'(3);
      tick();
      start = 1'b0;
      check("t1_done_start_busy", int'(busy), 0);
      tick();
      check("t1_done_start_busy2", int'(busy), 0);
      check("t1_hs_cnt", hs_cnt, 5);
      check("t1_first_hs", hs_cyc[0], s + 1);
      check("t1_last_hs", hs_cyc[4], s + 9);
      check("t1_done_cyc", done_cyc, s + 10);
      check("t1_overflow", int'(overflow), 0);

      // 2: overflow stops after 13
      start_seq(10, s);
      wait_done(60, "t2");
      check("t2_overflow", int'(overflow), 1);
      tick();
      check("t2_hs_cnt", hs_cnt, 8);
      check("t2_last_term", last_term, 13);
      check("t2_done_cyc", done_cyc, s + 18);
      repeat (3) tick();
      check("t2_ovf_sticky", int'(overflow), 1);

      // 6: overflow clears on the next accepted start
      start_seq(3, s);
      check("t6_ovf_cleared", int'(overflow), 0);
      wait_done(40, "t6");
      tick();
      check("t6_hs_cnt", hs_cnt, 3);
      check("t6_last_term", last_term, 1);
      check("t6_overflow", int'(overflow), 0);

      // 3: zero terms
      start_seq(0, s);
      check("t3_done", int'(done), 1);
      check("t3_busy", int'(busy), 0);
      check("t3_valid", int'(term_valid), 0);
      tick();
      check("t3_done_cyc", done_cyc, s);
      check("t3_done_after", int'(done), 0);
      check("t3_busy_after", int'(busy), 0);
      check("t3_hs_cnt", hs_cnt, 0);

      // 4: ready pattern 0,0,1 per term, stray start mid-run
      term_ready = 1'b0;
      start_seq(4, s);
      for (int k = 0; k < 4; k++) begin
         wait_valid(20, "t4");
         if (k == 2) begin
            start = 1'b1;
            n_terms = CNT_W'(7);
         end
         tick();
         start = 1'b0;
         tick();
         term_ready = 1'b1;
         tick();
         term_ready = 1'b0;
      end
      check("t4_done_now", int'(done), 1);
      tick();
      check("t4_hs_cnt", hs_cnt, 4);
      check("t4_last_term", last_term, 2);
      check("t4_done_cyc", done_cyc, hs_cyc[3] + 1);

      // 5: reset while the third term is waiting
      term_ready = 1'b1;
      start_seq(5, s);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (hs_cnt == 2 && term_valid) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("t5_reached_third", int'(found), 1);
      reset = 1'b1;
      term_ready = 1'b0;
      tick();
      check_all_zero("t5_after_reset");
      exp_q.delete();
      exp_active = 1'b0;
      reset = 1'b0;
      repeat (2) tick();
      check("t5_idle_busy", int'(busy), 0);
      term_ready = 1'b1;
      start_seq(2, s);
      wait_done(20, "t5");
      tick();
      check("t5_hs_cnt", hs_cnt, 2);
      check("t5_last_term", last_term, 1);

      // Boundaries: exactly 8 terms fits, 9 overflows, single term
      start_seq(8, s);
      wait_done(40, "b8");
      check("b8_overflow", int'(overflow), 0);
      tick();
      check("b8_hs_cnt", hs_cnt, 8);
      check("b8_done_cyc", done_cyc, s + 16);

      start_seq(9, s);
      wait_done(40, "b9");
      check("b9_overflow", int'(overflow), 1);
      tick();
      check("b9_hs_cnt", hs_cnt, 8);

      start_seq(1, s);
      wait_done(20, "b1");
      tick();
      check("b1_hs_cnt", hs_cnt, 1);
      check("b1_done_cyc", done_cyc, s + 2);
      check("b1_overflow", int'(overflow), 0);

      start_seq(31, s);
      wait_done(60, "b31");
      check("b31_overflow", int'(overflow), 1);
      tick();
      check("b31_hs_cnt", hs_cnt, 8);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
